dsp_route_sequencer: RTL and testbench

Bus-master sequencer that replays a programmed table of routing writes (`input_select` / `output_select` of the DSP router) onto the DSP system bus when a trigger arrives. Each write can be preceded by a programmable delay. This lets the PS retarget PID/IQ/IIR/scope/PWM routing deterministically relative to a hardware event, instead of through slow, jittery software writes. It sits between the PS configuration bus, a trigger source (ASG/scope trigger or external), and the DSP block's `sys_*` slave port.

---
 rtl/dsp_route_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dsp_route_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_route_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_route_sequencer
//
// Bus-master sequencer that replays a programmed table of DSP router writes
// (input_select / output_select) onto the DSP system bus when a trigger
// arrives. Each table entry carries its own pre-write delay, so routing can be
// retargeted deterministically relative to a hardware event.
//
// Ports:
//   clk_i, rst_i           processing clock, asynchronous active-high reset
//   cfg_addr/wdata/wen/ren PS configuration bus request
//   cfg_rdata, cfg_ack     registered configuration response (one cycle later)
//   trig_i                 hardware trigger, rising edge active
//   m_addr, m_wdata, m_wen master write toward the DSP sys_* slave port
//   m_ack_i, m_err_i       slave acknowledge / error (error qualified by ack)
//   busy_o, done_o, err_o  sequencer status
//
// Register map (byte addresses):
//   0x00 CTRL   W   bit0 arm, bit1 soft trigger, bit2 abort (self-clearing)
//   0x04 COUNT  RW  [4:0] number of entries, clamped to DEPTH
//   0x08 STATUS R   bit0 busy, bit1 done, bit2 err, bit3 armed, [7:4] index
//   0x40+4k TABLE[k] RW [3:0] module, [4] sel, [11:8] value, [31:16] delay
// -----------------------------------------------------------------------------
module dsp_route_sequencer #(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] BASE    = 32'h4030_0000,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_wen,
    input  logic        cfg_ren,
    output logic [31:0] cfg_rdata,
    output logic        cfg_ack,
    input  logic        trig_i,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_wen,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ENTRY_MASK = 32'hFFFF_0F1F;
    localparam logic [4:0]  DEPTH_W    = 5'(DEPTH);
    localparam logic [5:0]  DEPTH_K    = 6'(DEPTH);
    // Timer starts at 0 on ACK entry; reaching TIMEOUT after an increment
    // ends the wait, so the last tolerated value before expiry is TIMEOUT-1.
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    // DSP block register address for a table entry's module/selector pair.
    function automatic logic [31:0] f_entry_addr(input logic [3:0] module_id,
                                                 input logic       sel);
        logic [31:0] v_off;
        v_off = sel ? 32'h0000_0004 : 32'h0000_0000;
        return BASE + {12'h000, module_id, 16'h0000} + v_off;
    endfunction

    // ---------------------------------------------------------------- state
    state_t      r_state;
    logic [31:0] r_table [DEPTH];
    logic [4:0]  r_count;
    logic [3:0]  r_idx;
    logic [15:0] r_cnt;
    logic [15:0] r_timer;
    logic        r_trig;
    logic        r_arm;
    logic        r_soft;
    logic        r_abort;
    logic        r_cfg_ack;
    logic [31:0] r_cfg_rdata;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic        r_m_wen;
    logic        r_done;
    logic        r_err;

    // ---------------------------------------------------------------- decode
    logic          w_busy;
    logic          w_armed;
    logic          w_trig;
    logic [7:0]    w_tbl_off;
    logic [5:0]    w_tbl_k;
    logic          w_tbl_ok;
    logic [AW-1:0] w_tbl_idx;
    logic [4:0]    w_next_idx;
    logic          w_last;
    logic [31:0]   w_rdata;

    assign w_busy     = (r_state == S_WAIT) || (r_state == S_WRITE) || (r_state == S_ACK);
    assign w_armed    = (r_state == S_ARMED);
    assign w_trig     = (trig_i & ~r_trig) | r_soft;
    assign w_tbl_off  = cfg_addr - 8'h40;
    assign w_tbl_k    = w_tbl_off[7:2];
    assign w_tbl_ok   = (cfg_addr >= 8'h40) && (cfg_addr[1:0] == 2'b00) && (w_tbl_k < DEPTH_K);
    assign w_tbl_idx  = w_tbl_k[AW-1:0];
    assign w_next_idx = {1'b0, r_idx} + 5'd1;
    assign w_last     = (w_next_idx == r_count);

    // Configuration read mux; unmapped and write-only locations read as zero.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (cfg_addr == 8'h04) begin
            w_rdata = {27'h000_0000, r_count};
        end else if (cfg_addr == 8'h08) begin
            w_rdata = {24'h00_0000, r_idx, w_armed, r_err, r_done, w_busy};
        end else if (w_tbl_ok) begin
            w_rdata = r_table[w_tbl_idx];
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // Config response and CTRL pulse capture; CTRL acts in the ack cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cfg_ack   <= 1'b0;
            r_cfg_rdata <= 32'h0000_0000;
            r_arm       <= 1'b0;
            r_soft      <= 1'b0;
            r_abort     <= 1'b0;
            r_trig      <= 1'b0;
        end else begin
            r_cfg_ack   <= cfg_wen | cfg_ren;
            r_cfg_rdata <= cfg_ren ? w_rdata : 32'h0000_0000;
            r_arm       <= cfg_wen && (cfg_addr == 8'h00) && cfg_wdata[0];
            r_soft      <= cfg_wen && (cfg_addr == 8'h00) && cfg_wdata[1];
            r_abort     <= cfg_wen && (cfg_addr == 8'h00) && cfg_wdata[2];
            r_trig      <= trig_i;
        end
    end

    // COUNT and TABLE storage; frozen while a sequence is running.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 32'h0000_0000;
            end
        end else if (cfg_wen && !w_busy) begin
            if (cfg_addr == 8'h04) begin
                r_count <= (cfg_wdata > 32'(DEPTH)) ? DEPTH_W : cfg_wdata[4:0];
            end else if (w_tbl_ok) begin
                r_table[w_tbl_idx] <= cfg_wdata & ENTRY_MASK;
            end else begin
                r_count <= r_count;
            end
        end else begin
            r_count <= r_count;
        end
    end

    // Sequencer FSM with registered master-bus outputs and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_cnt     <= 16'd0;
            r_timer   <= 16'd0;
            r_m_addr  <= 32'h0000_0000;
            r_m_wdata <= 32'h0000_0000;
            r_m_wen   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_m_wen <= 1'b0;
            if (r_abort) begin
                // Abort overrides everything, including a same-cycle arm;
                // done/err keep the outcome of the previous run.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_arm) begin
                            r_state <= S_ARMED;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_ARMED: begin
                        if (w_trig) begin
                            if (r_count == 5'd0) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx   <= 4'd0;
                                r_cnt   <= r_table[0][31:16];
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt == 16'd0) begin
                            // Address/data are loaded here so they are
                            // already stable in the m_wen cycle.
                            r_state   <= S_WRITE;
                            r_m_wen   <= 1'b1;
                            r_m_addr  <= f_entry_addr(r_table[r_idx[AW-1:0]][3:0],
                                                      r_table[r_idx[AW-1:0]][4]);
                            r_m_wdata <= {28'h000_0000, r_table[r_idx[AW-1:0]][11:8]};
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    S_WRITE: begin
                        r_state <= S_ACK;
                        r_timer <= 16'd0;
                    end
                    S_ACK: begin
                        if (m_ack_i) begin
                            if (m_err_i) begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                            end else if (w_last) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx   <= w_next_idx[3:0];
                                r_cnt   <= r_table[w_next_idx[AW-1:0]][31:16];
                                r_state <= S_WAIT;
                            end
                        end else if (r_timer == TMO_LAST) begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_ack   = r_cfg_ack;
    assign cfg_rdata = r_cfg_rdata;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    // An abort landing on the write cycle must suppress the strobe at once.
    assign m_wen     = r_m_wen & ~r_abort;
    assign busy_o    = w_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule

// File: tb/tb_dsp_route_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for dsp_route_sequencer. Inputs change 1 ns
// after the rising edge; outputs are sampled at the same point, so a sample
// taken in cycle c reflects the state registered at the edge opening c.
// -----------------------------------------------------------------------------
module tb_dsp_route_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  cfg_addr = 8'h00;
    logic [31:0] cfg_wdata = 32'h0000_0000;
    logic        cfg_wen = 1'b0;
    logic        cfg_ren = 1'b0;
    logic [31:0] cfg_rdata;
    logic        cfg_ack;
    logic        trig_i = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_wen;
    logic        m_ack_i = 1'b0;
    logic        m_err_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    dsp_route_sequencer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_wen   (cfg_wen),
        .cfg_ren   (cfg_ren),
        .cfg_rdata (cfg_rdata),
        .cfg_ack   (cfg_ack),
        .trig_i    (trig_i),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wen     (m_wen),
        .m_ack_i   (m_ack_i),
        .m_err_i   (m_err_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          ack_mode = 0;     // 0: never ack, 1: ack next cycle, 2: ack, error on err_entry
    int          err_entry = 0;
    logic        prev_wen = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_err = 1'b0;
    int          wen_cnt = 0;
    int          wen_cyc[$];
    logic [31:0] wen_addr[$];
    logic [31:0] wen_data[$];
    int          done_cyc = -1;
    int          err_cyc = -1;
    int          overlap = 0;
    int          t = 0;
    logic [31:0] rd;
    logic        found;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: slave model answers the previous cycle's strobe, log events.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        m_ack_i = (ack_mode != 0) && prev_wen;
        m_err_i = (ack_mode == 2) && prev_wen && ((wen_cnt - 1) == err_entry);
        prev_wen = m_wen;
        if (m_wen) begin
            wen_cnt++;
            wen_cyc.push_back(cyc);
            wen_addr.push_back(m_addr);
            wen_data.push_back(m_wdata);
        end
        if (done_o && !prev_done) done_cyc = cyc;
        if (err_o && !prev_err) err_cyc = cyc;
        prev_done = done_o;
        prev_err  = err_o;
        if (busy_o && done_o) overlap++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        wen_cnt  = 0;
        wen_cyc.delete();
        wen_addr.delete();
        wen_data.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    // Returns in the cfg_ack cycle.
    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_wen   = 1'b1;
        step();
        cfg_wen   = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        cfg_addr = a;
        cfg_ren  = 1'b1;
        step();
        cfg_ren  = 1'b0;
        check_vec("cfg_ack", {31'd0, cfg_ack}, 32'd1);
        d = cfg_rdata;
    endtask

    // Arm, let ARMED settle, then raise trig_i; t is the sampling cycle.
    task automatic arm_and_trigger();
        cfg_write(8'h00, 32'h0000_0001);
        step();
        clear_log();
        trig_i = 1'b1;
        t = cyc;
        step();
        trig_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state
        run(3);
        check_vec("rst_flags", {27'd0, m_wen, busy_o, done_o, err_o, cfg_ack}, 32'd0);
        check_vec("rst_m_addr", m_addr, 32'h0000_0000);
        check_vec("rst_m_wdata", m_wdata, 32'h0000_0000);
        check_vec("rst_cfg_rdata", cfg_rdata, 32'h0000_0000);
        rst_i = 1'b0;
        step();
        cfg_read(8'h08, rd);
        check_vec("rst_status", rd, 32'h0000_0000);

        // ---------------- basic sequence
        ack_mode = 1;
        cfg_write(8'h40, 32'h0000_0B00);
        cfg_write(8'h04, 32'h0000_0001);
        cfg_write(8'h00, 32'h0000_0001);
        step();
        cfg_read(8'h08, rd);
        check_vec("armed_status", rd, 32'h0000_0008);
        clear_log();
        trig_i = 1'b1;
        t = cyc;
        step();
        trig_i = 1'b0;
        run(8);
        check_vec("basic_wen_cnt", wen_cnt, 1);
        if (wen_cnt >= 1) begin
            check_vec("basic_wen_cyc", wen_cyc[0] - t, 2);
            check_vec("basic_addr", wen_addr[0], 32'h4030_0000);
            check_vec("basic_data", wen_data[0], 32'd11);
        end
        check_vec("basic_done_cyc", done_cyc - t, 4);
        check_vec("basic_done", {31'd0, done_o}, 32'd1);

        // ---------------- multi-entry with delay
        cfg_write(8'h40, 32'h0000_0109);
        cfg_write(8'h44, 32'h000A_0209);
        cfg_write(8'h48, 32'h0000_0319);
        cfg_write(8'h04, 32'h0000_0003);
        arm_and_trigger();
        check_vec("arm_clears_done", {31'd0, done_o}, 32'd0);
        run(25);
        check_vec("multi_wen_cnt", wen_cnt, 3);
        if (wen_cnt >= 3) begin
            check_vec("multi_first", wen_cyc[0] - t, 2);
            check_vec("multi_gap1", wen_cyc[1] - wen_cyc[0], 13);
            check_vec("multi_gap2", wen_cyc[2] - wen_cyc[1], 3);
            check_vec("multi_addr0", wen_addr[0], 32'h4039_0000);
            check_vec("multi_addr2", wen_addr[2], 32'h4039_0004);
            check_vec("multi_data2", wen_data[2], 32'd3);
        end
        check_vec("multi_done", {30'd0, done_o, err_o}, 32'd2);

        // ---------------- ack timeout
        ack_mode = 0;
        cfg_write(8'h04, 32'h0000_0001);
        arm_and_trigger();
        run(270);
        check_vec("tmo_wen_cnt", wen_cnt, 1);
        if (wen_cnt >= 1) begin
            check_vec("tmo_err_delay", err_cyc - wen_cyc[0], 256);
        end
        check_vec("tmo_flags", {29'd0, busy_o, done_o, err_o}, 32'd1);

        // ---------------- slave error on entry 1 of 4, count clamp
        for (int k = 0; k < 4; k++) begin
            cfg_write(8'(8'h40 + 4 * k), 32'((k + 1) << 8) | 32'(k));
        end
        cfg_write(8'h04, 32'h0000_0004);
        ack_mode  = 2;
        err_entry = 1;
        arm_and_trigger();
        run(20);
        check_vec("serr_wen_cnt", wen_cnt, 2);
        if (wen_cnt >= 2) begin
            check_vec("serr_addr1", wen_addr[1], 32'h4031_0000);
            check_vec("serr_data1", wen_data[1], 32'd2);
        end
        check_vec("serr_err", {31'd0, err_o}, 32'd1);
        cfg_read(8'h08, rd);
        check_vec("serr_status", rd, 32'h0000_0014);
        cfg_write(8'h04, 32'd20);
        cfg_read(8'h04, rd);
        check_vec("count_clamp", rd, 32'd8);
        cfg_write(8'h60, 32'h0000_0F0F);
        cfg_read(8'h60, rd);
        check_vec("table_oob_read", rd, 32'h0000_0000);

        // ---------------- ignored events
        ack_mode = 1;
        clear_log();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        run(5);
        cfg_write(8'h00, 32'h0000_0002);
        run(5);
        check_vec("idle_trig_wen", wen_cnt, 0);
        check_vec("idle_trig_busy", {31'd0, busy_o}, 32'd0);
        cfg_write(8'h00, 32'h0000_0005);
        step();
        cfg_read(8'h08, rd);
        check_vec("abort_arm_status", rd, 32'h0000_0014);

        cfg_write(8'h40, 32'h0064_0109);
        cfg_write(8'h04, 32'h0000_0001);
        arm_and_trigger();
        run(3);
        check_vec("wait_busy", {31'd0, busy_o}, 32'd1);
        cfg_write(8'h00, 32'h0000_0004);
        check_vec("abort_ack_busy", {31'd0, busy_o}, 32'd1);
        step();
        check_vec("abort_busy_drop", {31'd0, busy_o}, 32'd0);
        run(3);
        cfg_read(8'h08, rd);
        check_vec("abort_status", rd, 32'h0000_0000);
        check_vec("abort_wen_cnt", wen_cnt, 0);

        // ---------------- busy table write, then reset during WRITE
        ack_mode = 0;
        cfg_write(8'h40, 32'h0014_0209);
        arm_and_trigger();
        run(2);
        cfg_write(8'h40, 32'h0000_0F05);
        cfg_read(8'h40, rd);
        check_vec("busy_table_write", rd, 32'h0014_0209);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_wen) begin
                found = 1'b1;
                break;
            end
        end
        check_vec("rst_wen_seen", {31'd0, found}, 32'd1);
        check_vec("rst_pre_addr", m_addr, 32'h4039_0000);
        check_vec("rst_pre_data", m_wdata, 32'd2);
        rst_i = 1'b1;
        #1;
        check_vec("rst_async_wen", {31'd0, m_wen}, 32'd0);
        check_vec("rst_async_flags", {28'd0, busy_o, done_o, err_o, cfg_ack}, 32'd0);
        check_vec("rst_async_addr", m_addr, 32'h0000_0000);
        step();
        step();
        rst_i = 1'b0;
        step();
        cfg_read(8'h40, rd);
        check_vec("rst_table_clear", rd, 32'h0000_0000);
        cfg_read(8'h04, rd);
        check_vec("rst_count_clear", rd, 32'h0000_0000);

        check_vec("busy_done_excl", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
